conv3x3_stage: RTL and testbench
================================

CONV3X3_STAGE -- requirements
Module: conv3x3_stage

Interface
REQ-001 The block SHALL provide parameter IMG_W, default 640, pixels per line.
REQ-002 The block SHALL provide parameter IMG_H, default 480, lines per frame.
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port pix_in SHALL be an input, 8 bits, unsigned grey pixel in raster order.
REQ-006 Port pix_valid SHALL be an input, 1 bit, qualifying pix_in; no backpressure.
REQ-007 Port sof SHALL be an input, 1 bit, marking the first pixel of a frame; it is meaningful only with pix_valid.
REQ-008 Port conv_out SHALL be an output, 12 bits, signed two's-complement convolution result feeding the normalization stage.
REQ-009 Port conv_valid SHALL be an output, 1 bit, qualifying conv_out.
REQ-010 Port eof_out SHALL be an output, 1 bit, high with the last conv_valid of a frame.

Function
REQ-011 A pixel SHALL be accepted on every clock edge where pix_valid=1; idle gaps of any length SHALL be tolerated.
REQ-012 Position counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL tag each accepted pixel:
- col increments per accepted pixel.
- col wraps from IMG_W-1 to 0 and increments row.
- row wraps from IMG_H-1 to 0 after the last pixel.
REQ-013 An accepted pixel with sof=1 SHALL be tagged (0,0) regardless of the counters, resynchronising mid-frame.
REQ-014 Two line buffers, each IMG_W x 8 bits, SHALL hold the previous two lines; on acceptance they are read at col, line1 takes the old line0 entry, and line0 takes pix_in.
REQ-015 A 3x3 window W[r][c] SHALL shift left on acceptance only:
- r=0 is row-2, c=0 is col-2.
- The new right column is {line1, line0, pix_in}.
REQ-016 The kernel SHALL be fixed: row0 = {0, 1, 0}, row1 = {1, 2, 1}, row2 = {-1, 1, -1}.
- Positive weight sum is 6, negative weight sum is -2.
- Output range is -510..1530.
REQ-017 Arithmetic SHALL be exact signed, 12 bits, with no saturation or truncation.
REQ-018 A result SHALL be produced only for accepted pixels with row>=2 and col>=2, giving (IMG_W-2)*(IMG_H-2) results per frame; border pixels SHALL produce no output.
REQ-019 The result SHALL be a two-stage pipeline:
- Stage 1 registers three row partial sums.
- Stage 2 registers their total.
- conv_valid is asserted exactly 2 clock cycles after the acceptance edge of the triggering pixel.
- The pipeline advances every cycle and does not stall on pix_valid gaps.
REQ-020 conv_valid SHALL be a single-cycle pulse per result; conv_out SHALL hold its last value while conv_valid=0.
REQ-021 eof_out SHALL be asserted only in the same cycle as the conv_valid for pixel (IMG_H-1, IMG_W-1).
REQ-022 Line-buffer contents SHALL NOT affect outputs of rows 0 and 1, because outputs for those rows are gated by REQ-018.

Reset
REQ-023 While reset=0, the following SHALL be cleared: conv_out=0, conv_valid=0, eof_out=0, col=0, row=0, window registers, and pipeline valid flags.
REQ-024 Line-buffer storage SHALL NOT require reset.
REQ-025 Reset asserted mid-frame SHALL discard in-flight results: no conv_valid for them after reset.
REQ-026 After reset, the first accepted pixel SHALL be tagged (0,0) even if sof=0.

Verification (IMG_W=4, IMG_H=4)
REQ-027 Constant-frame test: constant 100 frame, pix_valid continuous -> exactly 4 results, each 400; first conv_valid 2 cycles after pixel (2,2); eof_out with the 4th result.
REQ-028 Maximum test: window rows 0-1 all 255, row2 = {0, 255, 0} -> 1530.
REQ-029 Minimum test: window rows 0-1 all 0, row2 = {255, 0, 255} -> -510 (12'hE02).
REQ-030 Gap test: repeat REQ-027 with 3 idle cycles inserted after every pixel -> identical value sequence, each result 2 cycles after its triggering pixel.
REQ-031 Resync test: sof pulsed at frame pixel 6, then a full constant-50 frame -> exactly 4 results of 200 after resync.
REQ-032 Mid-frame reset test: reset asserted mid-frame -> outputs 0 asynchronously; after release, a fresh frame yields exactly 4 correct results.

Source files
------------

// File: rtl/conv3x3_stage.sv
// Streaming 3x3 convolution with two line buffers, a sliding window and a
// two-stage adder pipeline; border pixels produce no output.
module conv3x3_stage #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        sof,
  output logic [11:0] conv_out,
  output logic        conv_valid,
  output logic        eof_out
);
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int STAGES = 2;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [7:0]    l0, l1;
  logic          trig, last;

  logic [7:0] lb0_mem [IMG_W];
  logic [7:0] lb1_mem [IMG_W];

  logic [2:0][2:0][7:0] win_q;
  logic [2:0][7:0]      new_col;
  logic [2:0][11:0]     ps_d, ps_q;
  logic [11:0]          conv_out_q;
  logic [STAGES:0]      vld_pipe, eof_pipe;

  // sof forces the tag to (0,0) so a mid-frame sof resynchronises the raster
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (pix_valid) begin
      if (cur_col == COL_MAX) begin
        col_d = '0;
        row_d = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  assign l0      = lb0_mem[cur_col];
  assign l1      = lb1_mem[cur_col];
  assign new_col = {pix_in, l0, l1};
  assign trig    = pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign last    = (cur_row == ROW_MAX) && (cur_col == COL_MAX);

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_mem[cur_col] <= l0;
      lb0_mem[cur_col] <= pix_in;
    end
  end

  // Row partial sums with kernel rows {0,1,0}, {1,2,1}, {-1,1,-1}
  always_comb begin
    ps_d[0] = {4'b0, win_q[0][1]};
    ps_d[1] = {4'b0, win_q[1][0]} + {3'b0, win_q[1][1], 1'b0} + {4'b0, win_q[1][2]};
    ps_d[2] = {4'b0, win_q[2][1]} - {4'b0, win_q[2][0]} - {4'b0, win_q[2][2]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      ps_q       <= '0;
      conv_out_q <= '0;
      vld_pipe   <= '0;
      eof_pipe   <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (pix_valid) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
          win_q[r][2] <= new_col[r];
        end
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], trig};
      eof_pipe <= {eof_pipe[STAGES-1:0], trig && last};
      if (vld_pipe[0]) ps_q <= ps_d;
      if (vld_pipe[1]) conv_out_q <= ps_q[0] + ps_q[1] + ps_q[2];
    end
  end

  assign conv_out   = conv_out_q;
  assign conv_valid = vld_pipe[STAGES];
  assign eof_out    = eof_pipe[STAGES];
endmodule

// File: tb/tb_conv3x3_stage.sv
// Directed bench for conv3x3_stage at 4x4: table-driven frames plus resync
// and mid-frame reset sequences, scoreboarding value, latency and eof.
module tb_conv3x3_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [11:0] conv_out;
  logic        conv_valid;
  logic        eof_out;

  conv3x3_stage #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .sof(sof), .conv_out(conv_out), .conv_valid(conv_valid), .eof_out(eof_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][7:0] pix;
    logic [3:0]       gap;
    logic [3:0][11:0] exp;
  } vec_t;

  vec_t        tbl [5];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [11:0] q_val[$];
  int          q_cyc[$];
  bit          q_eof[$];
  int          exp_cyc[$];
  bit          stray_eof = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (conv_valid) begin
      q_val.push_back(conv_out);
      q_cyc.push_back(cyc);
      q_eof.push_back(eof_out);
    end
    if (eof_out && !conv_valid) stray_eof = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_q();
    q_val.delete(); q_cyc.delete(); q_eof.delete(); exp_cyc.delete();
    stray_eof = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] v, input bit s, input int gap, output int dcyc);
    @(negedge clk);
    pix_in = v; sof = s; pix_valid = 1'b1;
    dcyc = cyc;
    repeat (gap) begin
      @(negedge clk);
      pix_valid = 1'b0; sof = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0; sof = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0][7:0] px, input int gap, input bit first_sof);
    int d;
    for (int i = 0; i < 16; i++) begin
      send_pix(px[i], first_sof && (i == 0), gap, d);
      if ((i / 4) >= 2 && (i % 4) >= 2) exp_cyc.push_back(d);
    end
  endtask

  task automatic check_res(input string nm, input logic [3:0][11:0] ex);
    repeat (6) @(negedge clk);
    chk({nm, " count"}, q_val.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < q_val.size() && k < exp_cyc.size()) begin
        chk($sformatf("%s val%0d", nm, k), int'($signed(q_val[k])), int'($signed(ex[k])));
        chk($sformatf("%s lat%0d", nm, k), q_cyc[k] - exp_cyc[k], 3);
        chk($sformatf("%s eof%0d", nm, k), int'(q_eof[k]), (k == 3) ? 1 : 0);
      end
    end
    chk({nm, " hold"}, int'($signed(conv_out)), int'($signed(ex[3])));
    chk({nm, " idle valid"}, int'(conv_valid), 0);
    chk({nm, " stray eof"}, int'(stray_eof), 0);
    clear_q();
  endtask

  initial begin
    logic [15:0][7:0] fr;
    logic [3:0][11:0] ex;
    int d;

    // constant 100, continuous and with 3-cycle gaps
    for (int i = 0; i < 16; i++) fr[i] = 8'd100;
    tbl[0].pix = fr; tbl[0].gap = 4'd0;
    tbl[1].pix = fr; tbl[1].gap = 4'd3;
    for (int k = 0; k < 4; k++) begin
      tbl[0].exp[k] = 12'd400;
      tbl[1].exp[k] = 12'd400;
    end
    // maximum: rows 0-1 at 255, row 2 = {0,255,0,0}
    for (int i = 0; i < 16; i++) fr[i] = (i < 8 || i == 9) ? 8'd255 : 8'd0;
    tbl[2].pix = fr; tbl[2].gap = 4'd0;
    tbl[2].exp[0] = 12'd1530; tbl[2].exp[1] = 12'd1020;
    tbl[2].exp[2] = 12'd765;  tbl[2].exp[3] = 12'd510;
    // minimum: rows 0-1 at 0, row 2 = {255,0,255,0}
    for (int i = 0; i < 16; i++) fr[i] = (i == 8 || i == 10) ? 8'd255 : 8'd0;
    tbl[3].pix = fr; tbl[3].gap = 4'd0;
    tbl[3].exp[0] = 12'hE02;  tbl[3].exp[1] = 12'd255;
    tbl[3].exp[2] = 12'd510;  tbl[3].exp[3] = 12'd510;
    // gradient p = 16*row + col + 10
    for (int i = 0; i < 16; i++) fr[i] = 8'(16 * (i / 4) + (i % 4) + 10);
    tbl[4].pix = fr; tbl[4].gap = 4'd1;
    tbl[4].exp[0] = 12'd76;   tbl[4].exp[1] = 12'd80;
    tbl[4].exp[2] = 12'd140;  tbl[4].exp[3] = 12'd144;

    #1 reset = 1'b0;
    #1;
    chk("reset conv_out", int'(conv_out), 0);
    chk("reset conv_valid", int'(conv_valid), 0);
    chk("reset eof_out", int'(eof_out), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_frame(tbl[v].pix, int'(tbl[v].gap), 1'b1);
      idle(1);
      check_res($sformatf("vec%0d", v), tbl[v].exp);
    end

    // resync: partial frame of 200s, sof at pixel 6 starts a constant-50 frame
    for (int i = 0; i < 6; i++) send_pix(8'd200, i == 0, 0, d);
    for (int i = 0; i < 16; i++) fr[i] = 8'd50;
    run_frame(fr, 0, 1'b1);
    idle(1);
    for (int k = 0; k < 4; k++) ex[k] = 12'd200;
    check_res("resync", ex);

    // mid-frame reset with results in flight, then fresh frame without sof
    for (int i = 0; i < 12; i++) send_pix(8'd100, i == 0, 0, d);
    @(negedge clk);
    pix_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst conv_out", int'(conv_out), 0);
    chk("midrst conv_valid", int'(conv_valid), 0);
    chk("midrst eof_out", int'(eof_out), 0);
    repeat (3) @(negedge clk);
    chk("midrst inflight", q_val.size(), 0);
    clear_q();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) fr[i] = 8'd100;
    run_frame(fr, 0, 1'b0);
    idle(1);
    for (int k = 0; k < 4; k++) ex[k] = 12'd400;
    check_res("postrst", ex);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
